// File: rtl/sync_pulse_mc.sv
// sync_pulse_mc: multi-channel single-cycle pulse synchronizer, clk_a -> clk_b.
// Each channel runs a four-phase req/ack handshake across the two clocks.
// Pulses arriving while a channel is busy are dropped (sticky err_a plus a
// saturating drop_cnt). Define SYNC_PULSE_MC_PEND_EN to give each channel a
// one-deep pending slot that absorbs the first pulse seen while busy.
`timescale 1ns/100ps
module sync_pulse_mc #(
   parameter int CH       = 4,
   parameter int SYNC_STG = 2,
   parameter int DROP_W   = 8
) (
   input  logic              clk_a,
   input  logic              clk_b,
   input  logic              rst_n,
   input  logic [CH-1:0]     pls_a,
   input  logic              clr_a,
   output logic [CH-1:0]     busy_a,
   output logic [CH-1:0]     err_a,
   output logic [DROP_W-1:0] drop_cnt,
   output logic [CH-1:0]     pls_b
);

   // Channel state is encoded directly as {req_a, ack_a}.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_DRAIN = 2'b01,
      ST_REQ   = 2'b10,
      ST_ACKED = 2'b11
   } ch_state_t;

   localparam int CNT_W = $clog2(CH + 1);
   localparam int SUM_W = ((DROP_W > CNT_W) ? DROP_W : CNT_W) + 1;
   localparam logic [DROP_W-1:0] CNT_MAX = {DROP_W{1'b1}};

   logic [CH-1:0]                req_a;
   logic [CH-1:0]                ack_a;
   logic [SYNC_STG-1:0][CH-1:0]  ack_sync;
   logic [SYNC_STG-1:0][CH-1:0]  req_sync;
   logic [CH-1:0]                req_b;
   logic [CH-1:0]                req_b_d;
   logic [CH-1:0]                launch;
   logic [CH-1:0]                drop;
   logic [CNT_W-1:0]             n_drop;
   logic [SUM_W-1:0]             cnt_sum;
   logic [DROP_W-1:0]            cnt_next;

   assign ack_a  = ack_sync[SYNC_STG-1];
   assign busy_a = req_a | ack_a;

`ifdef SYNC_PULSE_MC_PEND_EN
   logic [CH-1:0] pend;

   // An idle channel launches on a fresh pulse or a held one; a busy channel
   // drops only when its pending slot is already occupied.
   assign launch = ~busy_a & (pls_a | pend);
   assign drop   = busy_a & pls_a & pend;

   // Pending slot: fill while busy, release into req_a when idle, and keep a
   // pulse that lands in the same cycle as the release.
   always_ff @(posedge clk_a or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
      end else begin
         pend <= busy_a ? (pend | pls_a) : (pend & pls_a);
      end
   end
`else
   assign launch = ~busy_a & pls_a;
   assign drop   = busy_a & pls_a;
`endif

   // Per-channel handshake FSM; req_a is the registered output of each channel.
   always_ff @(posedge clk_a or negedge rst_n) begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         req_a <= '0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            case (ch_state_t'({req_a[i], ack_a[i]}))
               ST_IDLE:  req_a[i] <= launch[i];
               ST_REQ:   req_a[i] <= 1'b1;
               ST_ACKED: req_a[i] <= 1'b0;
               ST_DRAIN: req_a[i] <= 1'b0;
            endcase
         end
      end
   end

   // Acknowledge path: req_b resynchronised into clk_a.
   always_ff @(posedge clk_a or negedge rst_n) begin
      // NOTE: plain flop chain with no logic between stages gives metastability time to settle.
      if (!rst_n) begin
         ack_sync <= '0;
      end else begin
         ack_sync <= {ack_sync[SYNC_STG-2:0], req_b};
      end
   end

   // Request path: req_a resynchronised into clk_b, plus one delay stage for edge detect.
   always_ff @(posedge clk_b or negedge rst_n) begin
      if (!rst_n) begin
         req_sync <= '0;
         req_b_d  <= '0;
      end else begin
         req_sync <= {req_sync[SYNC_STG-2:0], req_a};
         req_b_d  <= req_b;
      end
   end

   assign req_b = req_sync[SYNC_STG-1];
   assign pls_b = req_b & ~req_b_d;

   // Count dropping channels this cycle and form the saturated next count.
   always_comb begin
      // NOTE: defaults first so no path through this block can infer a latch.
      n_drop   = '0;
      for (int i = 0; i < CH; i++) begin
         n_drop = n_drop + CNT_W'(drop[i]);
      end
      cnt_sum  = SUM_W'(drop_cnt) + SUM_W'(n_drop);
      cnt_next = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[DROP_W-1:0];
   end

   // Sticky error flags and drop counter; clr_a wins over same-cycle drops.
   always_ff @(posedge clk_a or negedge rst_n) begin
      if (!rst_n) begin
         err_a    <= '0;
         drop_cnt <= '0;
      end else if (clr_a) begin
         err_a    <= '0;
         drop_cnt <= '0;
      end else begin
         err_a    <= err_a | drop;
         drop_cnt <= cnt_next;
      end
   end

endmodule

// File: tb/tb_sync_pulse_mc.sv
// Bench for sync_pulse_mc: directed vectors on a CH=4/SYNC_STG=2/DROP_W=4
// instance (clk_b 37 MHz) and a spaced random stream on a SYNC_STG=3 instance
// (clk_b 250 MHz). Expected pls_b events go into scoreboards; monitors on the
// clk_b falling edge pop them and check latency.
`timescale 1ns/100ps
module tb_sync_pulse_mc;

   localparam int      CH  = 4;
   localparam int      S1  = 2;
   localparam int      S2  = 3;
   localparam int      DW  = 4;
   localparam realtime TA  = 10.0;
   localparam realtime TB  = 27.0;
   localparam realtime TB2 = 4.0;
`ifdef SYNC_PULSE_MC_PEND_EN
   localparam bit PEND = 1'b1;
`else
   localparam bit PEND = 1'b0;
`endif

   typedef struct {
      int      ch;
      realtime t;
      bit      timed;
   } exp_t;

   logic          clk_a, clk_b, clk_b2, rst_n;
   logic [CH-1:0] pls_a, busy_a, err_a, pls_b;
   logic          clr_a;
   logic [DW-1:0] drop_cnt;
   logic [CH-1:0] pls_a2, busy2, err2, pls_b2;
   logic          clr2;
   logic [DW-1:0] cnt2;

   exp_t    sb_q[$];
   realtime sb2_q[$];
   int      total, bad, n_out2;
   realtime t_edge;

   sync_pulse_mc #(.CH(CH), .SYNC_STG(S1), .DROP_W(DW)) u_dut (
      .clk_a(clk_a), .clk_b(clk_b), .rst_n(rst_n), .pls_a(pls_a), .clr_a(clr_a),
      .busy_a(busy_a), .err_a(err_a), .drop_cnt(drop_cnt), .pls_b(pls_b));

   sync_pulse_mc #(.CH(CH), .SYNC_STG(S2), .DROP_W(DW)) u_dut2 (
      .clk_a(clk_a), .clk_b(clk_b2), .rst_n(rst_n), .pls_a(pls_a2), .clr_a(clr2),
      .busy_a(busy2), .err_a(err2), .drop_cnt(cnt2), .pls_b(pls_b2));

   initial begin
      clk_a = 1'b0;
      forever #(TA/2) clk_a = ~clk_a;
   end
   initial begin
      clk_b = 1'b0;
      #1.3;
      forever #(TB/2) clk_b = ~clk_b;
   end
   initial begin
      clk_b2 = 1'b0;
      #0.7;
      forever #(TB2/2) clk_b2 = ~clk_b2;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic check_lat(input string name, input realtime lat, input realtime lo, input realtime hi);
      total++;
      if (!(lat > lo - 0.01 && lat <= hi + 0.01)) begin
         bad++;
         $display("FAIL %s: latency %0.1f ns, expected in (%0.1f, %0.1f]", name, lat, lo, hi);
      end
   endtask

   task automatic push(input int ch, input realtime t, input bit timed);
      exp_t e;
      e.ch = ch; e.t = t; e.timed = timed;
      sb_q.push_back(e);
   endtask

   // With a pending slot, the pulse it captures comes out later at an
   // unpredictable time: expect it, but skip the latency check.
   task automatic push_pend(input logic [CH-1:0] m);
      if (PEND) begin
         for (int i = 0; i < CH; i++) if (m[i]) push(i, 0.0, 1'b0);
      end
   endtask

   // One clk_a cycle of stimulus; inputs change 1 ns after the edge.
   task automatic drive(input logic [CH-1:0] p, input logic c);
      pls_a = p;
      clr_a = c;
      @(posedge clk_a);
      t_edge = $realtime;
      #1;
      pls_a = '0;
      clr_a = 1'b0;
   endtask

   task automatic fire(input logic [CH-1:0] p, input logic [CH-1:0] acc);
      drive(p, 1'b0);
      for (int i = 0; i < CH; i++) if (acc[i]) push(i, t_edge, 1'b1);
   endtask

   // Wait for all channels quiet for several cycles, then require every
   // expected pls_b to have been seen.
   task automatic wait_idle(input string name);
      int quiet = 0;
      int n = 0;
      while (quiet < 4 && n < 300) begin
         @(posedge clk_a);
         #1;
         quiet = (busy_a == '0) ? quiet + 1 : 0;
         n++;
      end
      check({name, "_idle"}, 32'(quiet >= 4), 32'd1);
      check({name, "_sb_left"}, sb_q.size(), 32'd0);
   endtask

   // Monitor for the main instance: every pls_b must match a queued event.
   always @(negedge clk_b) begin
      int idx;
      for (int i = 0; i < CH; i++) begin
         if (pls_b[i]) begin
            idx = -1;
            for (int j = 0; j < sb_q.size(); j++) begin
               if (idx < 0 && sb_q[j].ch == i) idx = j;
            end
            total++;
            if (idx < 0) begin
               bad++;
               $display("FAIL pls_b_unexpected ch%0d at %0.1f ns: got pulse, expected none", i, $realtime);
            end else begin
               if (sb_q[idx].timed)
                  check_lat($sformatf("pls_b_lat_ch%0d", i), $realtime - sb_q[idx].t,
                            (S1 - 1) * TB + TB/2, (S1 + 1) * TB + TB/2);
               sb_q.delete(idx);
            end
         end
      end
   end

   // Monitor for the fast instance: only channel 0 is ever driven.
   always @(negedge clk_b2) begin
      if (pls_b2[0]) begin
         n_out2++;
         total++;
         if (sb2_q.size() == 0) begin
            bad++;
            $display("FAIL pls_b2_unexpected at %0.1f ns: got pulse, expected none", $realtime);
         end else begin
            check_lat("pls_b2_lat", $realtime - sb2_q.pop_front(), (S2 - 1) * TB2 + TB2/2,
                      (S2 + 1) * TB2 + TB2/2);
         end
      end
      if (pls_b2[CH-1:1] != '0) begin
         total++;
         bad++;
         $display("FAIL pls_b2_idle_ch: got %b, expected 000", pls_b2[CH-1:1]);
      end
   end

   initial begin
      int gap;
      total = 0; bad = 0; n_out2 = 0;
      rst_n = 1'b0; pls_a = '0; clr_a = 1'b0; pls_a2 = '0; clr2 = 1'b0;
      repeat (3) @(posedge clk_a);
      #1;
      check("rst_busy", busy_a, 0);
      check("rst_err", err_a, 0);
      check("rst_cnt", drop_cnt, 0);
      check("rst_pls_b", pls_b, 0);
      @(posedge clk_a);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk_a);
      #1;
      check("post_rst_busy", busy_a, 0);

      // Single pulse from idle on ch0.
      fire(4'b0001, 4'b0001);
      check("t1_busy0", busy_a[0], 1);
      wait_idle("t1");
      check("t1_err", err_a, 0);
      check("t1_cnt", drop_cnt, 0);

      // All channels at once, all idle.
      fire(4'b1111, 4'b1111);
      wait_idle("t2");
      check("t2_err", err_a, 0);
      check("t2_cnt", drop_cnt, 0);

      // All channels busy, two more all-channel pulses: multi-drop per cycle.
      fire(4'b1111, 4'b1111);
      drive(4'b0000, 1'b0);
      drive(4'b1111, 1'b0);
      push_pend(4'b1111);
      drive(4'b0000, 1'b0);
      drive(4'b1111, 1'b0);
      check("t3_cnt", drop_cnt, PEND ? 4 : 8);
      check("t3_err", err_a, 4'b1111);
      drive(4'b0000, 1'b1);
      check("t3_clr_cnt", drop_cnt, 0);
      check("t3_clr_err", err_a, 0);
      wait_idle("t3");

      // Three pulses on ch1 spaced two cycles.
      fire(4'b0010, 4'b0010);
      drive(4'b0000, 1'b0);
      drive(4'b0010, 1'b0);
      push_pend(4'b0010);
      drive(4'b0000, 1'b0);
      drive(4'b0010, 1'b0);
      check("t4_err", err_a, 4'b0010);
      check("t4_cnt", drop_cnt, PEND ? 1 : 2);
      wait_idle("t4");
      drive(4'b0000, 1'b1);

      // Twenty drops on ch2 in four rounds of five: counter saturates at 15.
      for (int r = 0; r < 4; r++) begin
         fire(4'b0100, 4'b0100);
         for (int n = 0; n < (PEND ? 6 : 5); n++) begin
            drive(4'b0100, 1'b0);
            if (n == 0) push_pend(4'b0100);
         end
         wait_idle($sformatf("t5_r%0d", r));
         if (r == 1) check("t5_cnt10", drop_cnt, 10);
      end
      check("t5_cnt_sat", drop_cnt, 15);
      check("t5_err", err_a, 4'b0100);

      // clr_a in the same cycle as a drop: the drop is not recorded.
      fire(4'b0100, 4'b0100);
      drive(4'b0100, 1'b0);
      push_pend(4'b0100);
      drive(4'b0100, 1'b1);
      check("t5_clr_cnt", drop_cnt, 0);
      check("t5_clr_err", err_a, 0);
      wait_idle("t5_clr");

      // Reset while ch0/ch3 are in REQ: no pls_b, everything back to reset values.
      drive(4'b1001, 1'b0);
      drive(4'b1001, 1'b0);
      rst_n = 1'b0;
      #1;
      check("t6_rst_busy", busy_a, 0);
      check("t6_rst_err", err_a, 0);
      check("t6_rst_cnt", drop_cnt, 0);
      check("t6_rst_pls_b", pls_b, 0);
      repeat (8) @(posedge clk_b);
      @(posedge clk_a);
      #1;
      rst_n = 1'b1;
      @(posedge clk_a);
      #1;
      check("t6_rel_busy", busy_a, 0);
      fire(4'b1000, 4'b1000);
      wait_idle("t6");

      // 1000 spaced ch0 events on the SYNC_STG=3 / 250 MHz instance.
      for (int n = 0; n < 1000; n++) begin
         pls_a2 = 4'b0001;
         @(posedge clk_a);
         sb2_q.push_back($realtime);
         #1;
         pls_a2 = '0;
         gap = $urandom_range(25, 12);
         repeat (gap) @(posedge clk_a);
         #1;
      end
      repeat (30) @(posedge clk_a);
      #1;
      check("t7_count", n_out2, 1000);
      check("t7_sb_left", sb2_q.size(), 0);
      check("t7_cnt", cnt2, 0);
      check("t7_err", err2, 0);
      check("t7_busy", busy2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sync_pulse_mc.md
# sync_pulse_mc

Multi-channel pulse synchronizer that carries single-cycle event pulses from the clk_a domain to the clk_b domain. Each channel uses a four-phase req/ack handshake, and each channel exposes its busy state to the source. Pulses that arrive while a channel is busy are either held in a one-deep pending slot or dropped. Drops are recorded in per-channel sticky error flags and in a saturating drop counter. The block replaces single-channel pulse sync instances wherever several control events cross between the same pair of clocks.

## Interface
- CH, 4, number of independent channels (1..32)
- SYNC_STG, 2, synchronizer flops per crossing direction (2..4)
- DROP_W, 8, width of drop counter

- clk_a  input  1  source clock
- clk_b  input  1  destination clock
- rst_n  input  1  reset rst_n, asynchronous, active-low; clock clk_a (also asynchronously clears all clk_b-domain flops)
- pls_a  input  CH  per-channel event pulse, clk_a domain; one cycle high per event
- clr_a  input  1  clk_a; clears err_a and drop_cnt
- busy_a  output  CH  channel handshake in progress (req_a | ack_a)
- err_a  output  CH  sticky: at least one pulse dropped on that channel
- drop_cnt  output  DROP_W  saturating total drop count across all channels
- pls_b  output  CH  per-channel one-cycle pulse, clk_b domain

## Operation
- Per channel, clk_a domain:
  - req_a register.
  - ack_a = last flop of a SYNC_STG-deep chain in clk_a sampling req_b.
  - busy_a = req_a | ack_a.
- Per channel, clk_b domain:
  - req_b = last flop of a SYNC_STG-deep chain sampling req_a.
  - req_b_d = req_b delayed one clk_b cycle.
  - pls_b = req_b & ~req_b_d, decoded from flops only.
- Channel state machine (clk_a): IDLE (req=0, ack=0) -> REQ (req=1, ack=0) -> ACKED (req=1, ack=1) -> DRAIN (req=0, ack=1) -> IDLE.
  - IDLE->REQ: on accept.
  - REQ->ACKED: when ack_a rises.
  - ACKED->DRAIN: on the next clk_a edge, req_a clears.
  - DRAIN->IDLE: when ack_a falls.
- Accept: a channel accepts when busy_a=0 in the cycle where pls_a=1 (or pend=1); req_a is set at that edge.
- busy_a=1 for any pls_a means the pulse is not accepted directly. It goes to pending (if enabled) or is dropped.
- Drop: err_a[i] is set on the next edge. drop_cnt adds the number of channels dropping in that cycle (0..CH) and saturates at 2^DROP_W-1; it never wraps.
- clr_a=1: err_a and drop_cnt go to 0. clr_a has priority over drops in the same cycle, so those drops are not recorded.
- Each accepted event produces exactly one pls_b on its channel. Channels are fully independent; simultaneous pulses on all channels all succeed if the channels are idle.

## Timing
- Reset values: req/ack/pend/sync flops 0, busy_a=0, err_a=0, drop_cnt=0, pls_b=0.
- rst_n assertion at any point aborts in-flight handshakes with no pls_b emitted; after release every channel is IDLE.
- Latency: pls_a accepted at clk_a edge k. pls_b goes high after the SYNC_STG-th clk_b edge following k and lasts exactly one clk_b cycle. The clk_b sampling uncertainty adds 0..1 clk_b cycle.
- busy_a duration per event: about 2·SYNC_STG·(Ta+Tb) plus 1–2 Ta, with a bound of (2·SYNC_STG+2)·(Ta+Tb). The next direct accept is possible in the first cycle busy_a=0.
- A pls_a in the same cycle that busy_a falls to 0 counts as busy. busy_a is evaluated on the current register state.
- Inputs pls_a and clr_a are synchronous to clk_a; there are no other timing constraints.

## Configuration
- SYNC_PULSE_MC_PEND_EN defined: each channel has a pend flop.
  - A pls_a while busy with pend=0 sets pend; it is not a drop.
  - A pls_a while busy with pend=1 is a drop.
  - When busy_a=0 and pend=1, req_a is set and pend clears at that edge.
  - If pls_a arrives in that same cycle, pend stays 1 and holds the new pulse.
  - busy_a is unchanged (pend is not visible on busy_a).
- Not defined: there is no pend logic, and every pls_a while busy_a=1 is a drop.

## Test plan
- Config: CH=4, SYNC_STG=2, DROP_W=4, clk_a 100 MHz, clk_b 37 MHz.
- Single pulse on ch0 from idle -> one pls_b[0] 2–3 clk_b cycles later; busy_a[0] returns to 0; err_a=0, drop_cnt=0.
- pls_a=4'b1111 in one cycle -> one pls_b on each channel; no drops.
- Without PEND_EN, 3 pulses on ch1 spaced 2 clk_a cycles -> one pls_b[1], err_a[1]=1, drop_cnt=2. With PEND_EN -> two pls_b[1], drop_cnt=1.
- 20 drops on ch2 with DROP_W=4 -> drop_cnt saturates at 15. Then clr_a in the same cycle as a drop -> drop_cnt=0, err_a=0.
- rst_n pulsed while ch3 is in REQ -> no pls_b[3]; all outputs at reset values; a fresh pulse after release yields exactly one pls_b[3].
- Swap to clk_b 250 MHz and SYNC_STG=3 -> the ch0 pulse count in equals the pls_b count out over 1000 random spaced events, with zero drops when spacing exceeds the busy bound.
